// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and codes for the multicycle control FSM:
// state enum, opcodes, ALU function codes, immediate-extension codes.
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    C_ALU,
    C_B,
    C_BEQ,
    C_BNE,
    C_LW,
    C_SW,
    C_ILL
  } iclass_t;

  localparam logic [5:0] OP_R    = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_ANDI = 6'b110010;
  localparam logic [5:0] OP_ORI  = 6'b110011;
  localparam logic [5:0] OP_B    = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b000000;
  localparam logic [5:0] OP_BNE  = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SW   = 6'b011111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [1:0] IMM_SEXT = 2'b00;
  localparam logic [1:0] IMM_ZEXT = 2'b01;
  localparam logic [1:0] IMM_SHL2 = 2'b11;

  function automatic iclass_t op_class(
    input logic [5:0] op
  );
    iclass_t c;
    unique case (1'b1)
      (op == OP_R),
      (op == OP_ADDI),
      (op == OP_ANDI),
      (op == OP_ORI): c = C_ALU;
      (op == OP_B):   c = C_B;
      (op == OP_BEQ): c = C_BEQ;
      (op == OP_BNE): c = C_BNE;
      (op == OP_LW):  c = C_LW;
      (op == OP_SW):  c = C_SW;
      default:        c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational decode of latched opcode/func into ALU, immediate and
// RF-B selects plus instruction class. Ports: opcode, func -> alu_func,
// alu_bin_sel, immed_sel, rf_b_sel, cls.
module ctrl_decode
  import multicycle_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [3:0] func,
  output logic [3:0] alu_func,
  output logic       alu_bin_sel,
  output logic [1:0] immed_sel,
  output logic       rf_b_sel,
  output iclass_t    cls
);

  always_comb begin
    alu_func    = ALU_ADD;
    alu_bin_sel = 1'b0;
    immed_sel   = IMM_SEXT;
    rf_b_sel    = 1'b0;
    cls         = op_class(opcode);
    unique case (1'b1)
      (opcode == OP_R): begin
        alu_func = func;
      end
      (opcode == OP_ADDI),
      (opcode == OP_LW): begin
        alu_bin_sel = 1'b1;
      end
      (opcode == OP_SW): begin
        alu_bin_sel = 1'b1;
        rf_b_sel    = 1'b1;
      end
      (opcode == OP_ANDI): begin
        alu_func    = ALU_AND;
        alu_bin_sel = 1'b1;
        immed_sel   = IMM_ZEXT;
      end
      (opcode == OP_ORI): begin
        alu_func    = ALU_OR;
        alu_bin_sel = 1'b1;
        immed_sel   = IMM_ZEXT;
      end
      (opcode == OP_BEQ),
      (opcode == OP_BNE): begin
        alu_func  = ALU_SUB;
        immed_sel = IMM_SHL2;
        rf_b_sel  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing of PC, RF,
// ALU and data memory (req/ack).
// Ports: clk, reset (async high), instr, alu_zero, mem_ack -> pc_en, pc_sel,
// rf_wr_en, rf_wd_sel, rf_b_sel, alu_bin_sel, alu_func, immed_sel, mem_req,
// mem_we, err. Optional MEM timeout: MULTICYCLE_CTRL_MEM_TIMEOUT_EN.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        rf_wr_en,
  output logic        rf_wd_sel,
  output logic        rf_b_sel,
  output logic        alu_bin_sel,
  output logic [3:0]  alu_func,
  output logic [1:0]  immed_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        err
);

  state_t     state, state_n;
  logic [5:0] op_q;
  logic [3:0] func_q;
  logic       err_set;
  logic       mem_to;

  logic [3:0] d_alu_func;
  logic       d_bin_sel;
  logic [1:0] d_immed_sel;
  logic       d_rf_b_sel;
  iclass_t    d_cls;
  iclass_t    f_cls;

  logic unused_instr;
  assign unused_instr = ^instr[25:4];

  ctrl_decode u_dec (
    .opcode      (op_q),
    .func        (func_q),
    .alu_func    (d_alu_func),
    .alu_bin_sel (d_bin_sel),
    .immed_sel   (d_immed_sel),
    .rf_b_sel    (d_rf_b_sel),
    .cls         (d_cls)
  );

  // DECODE has to act before the latch is loaded, so it classifies
  // the live instruction word directly.
  assign f_cls = op_class(instr[31:26]);

`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state != S_MEM) begin
      to_cnt <= '0;
    end else if (!mem_ack) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Fires in the MEM_TIMEOUT-th MEM cycle; an ack there still wins.
  assign mem_to = (state == S_MEM) && !mem_ack
               && (to_cnt == TO_W'(MEM_TIMEOUT - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (MEM_TIMEOUT >= 2**TO_W);
  assign mem_to     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_FETCH;
      op_q   <= '0;
      func_q <= '0;
      err    <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) begin
        op_q   <= instr[31:26];
        func_q <= instr[3:0];
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n     = state;
    err_set     = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    rf_wr_en    = 1'b0;
    rf_wd_sel   = 1'b0;
    rf_b_sel    = 1'b0;
    alu_bin_sel = 1'b0;
    alu_func    = 4'b0000;
    immed_sel   = 2'b00;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    // Operand selects stay on from EXEC through MEM and WB.
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      alu_func    = d_alu_func;
      alu_bin_sel = d_bin_sel;
      immed_sel   = d_immed_sel;
      rf_b_sel    = d_rf_b_sel;
    end
    unique case (state)
      S_FETCH: begin
        state_n = S_DECODE;
      end
      S_DECODE: begin
        unique case (f_cls)
          C_B: begin
            pc_en     = 1'b1;
            pc_sel    = 1'b1;
            immed_sel = IMM_SHL2;
            state_n   = S_FETCH;
          end
          C_ILL: begin
            pc_en   = 1'b1;
            err_set = 1'b1;
            state_n = S_FETCH;
          end
          default: state_n = S_EXEC;
        endcase
      end
      S_EXEC: begin
        unique case (d_cls)
          C_BEQ: begin
            pc_en   = 1'b1;
            pc_sel  = alu_zero;
            state_n = S_FETCH;
          end
          C_BNE: begin
            pc_en   = 1'b1;
            pc_sel  = ~alu_zero;
            state_n = S_FETCH;
          end
          C_LW,
          C_SW:    state_n = S_MEM;
          default: state_n = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (d_cls == C_SW);
        if (mem_ack) begin
          if (d_cls == C_SW) begin
            pc_en   = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end else if (mem_to) begin
          mem_req = 1'b0;
          mem_we  = 1'b0;
          err_set = 1'b1;
          pc_en   = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_WB: begin
        rf_wr_en  = 1'b1;
        rf_wd_sel = (d_cls == C_LW);
        pc_en     = 1'b1;
        state_n   = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios then random
// instructions against a per-instruction outcome model.
module tb_multicycle_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ack;
  logic        pc_en, pc_sel, rf_wr_en, rf_wd_sel, rf_b_sel;
  logic        alu_bin_sel, mem_req, mem_we, err;
  logic [3:0]  alu_func;
  logic [1:0]  immed_sel;

  int ncmp = 0;
  int nfail = 0;
  bit exp_err = 1'b0;

  logic [13:0] outs;
  logic [7:0]  ctl;
  assign outs = {pc_en, pc_sel, rf_wr_en, rf_wd_sel, rf_b_sel,
                 alu_bin_sel, alu_func, immed_sel, mem_req, mem_we};
  assign ctl  = {rf_b_sel, alu_bin_sel, alu_func, immed_sel};

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TMO), .TO_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .alu_zero    (alu_zero),
    .mem_ack     (mem_ack),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .rf_wr_en    (rf_wr_en),
    .rf_wd_sel   (rf_wd_sel),
    .rf_b_sel    (rf_b_sel),
    .alu_bin_sel (alu_bin_sel),
    .alu_func    (alu_func),
    .immed_sel   (immed_sel),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 ALU, 1 B, 2 BEQ, 3 BNE, 4 LW, 5 SW, 6 illegal
  function automatic int kind(input logic [5:0] op);
    case (op)
      6'b100000, 6'b110000, 6'b110010, 6'b110011: return 0;
      6'b111111: return 1;
      6'b000000: return 2;
      6'b000001: return 3;
      6'b001111: return 4;
      6'b011111: return 5;
      default:   return 6;
    endcase
  endfunction

  // {rf_b_sel, alu_bin_sel, alu_func, immed_sel} expected from EXEC on
  function automatic logic [7:0] exp_ctl(input logic [5:0] op,
                                         input logic [3:0] fn);
    case (op)
      6'b100000: return {2'b00, fn, 2'b00};
      6'b110000: return 8'b01_0000_00;
      6'b110010: return 8'b01_0010_01;
      6'b110011: return 8'b01_0011_01;
      6'b001111: return 8'b01_0000_00;
      6'b011111: return 8'b11_0000_00;
      default:   return 8'b10_0001_11;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_err = 1'b0;
  endtask

  // Entered at posedge+1 with the DUT in FETCH; leaves the same way.
  // z: 0/1 forces alu_zero in EXEC, 2 random. noack: never acknowledge.
  task automatic run_instr(input logic [5:0] op, input logic [3:0] fn,
                           input int w, input int z, input bit noack);
    int k = kind(op);
    bit mem = (k == 4) || (k == 5);
    int ecyc, ewr, ereq, c, ncyc, nwr, nreq, nwe;
    bit eto, done, sel_at, wd_at, z3;
    logic [1:0] imm2;
    logic [7:0] ex3, exl;
    eto = mem && noack;
    case (k)
      0: ecyc = 4;
      1, 6: ecyc = 2;
      2, 3: ecyc = 3;
      4: ecyc = 5 + w;
      default: ecyc = 4 + w;
    endcase
    if (eto) ecyc = 3 + TMO;
    ereq = eto ? TMO - 1 : (mem ? w + 1 : 0);
    ewr = ((k == 0) || (k == 4 && !eto)) ? 1 : 0;
    instr = {op, 22'($urandom), fn};
    c = 0; done = 0; ncyc = 0; nwr = 0; nreq = 0; nwe = 0;
    sel_at = 0; wd_at = 0; z3 = 0; imm2 = 0; ex3 = 0; exl = 0;
    while (!done && c < 40) begin
      c++;
      if (c > 1) begin @(posedge clk); #1; end
      alu_zero = 1'($urandom_range(0, 1));
      if (c == 3 && z != 2) alu_zero = z[0];
      if (mem && c >= 4 && c <= 4 + w)
        mem_ack = (c == 4 + w) && !noack;
      else
        mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (c == 1) begin
        chk("fetch_outs", 32'(outs), 32'd0);
        chk("err_hold", 32'(err), 32'(exp_err));
      end
      if (c == 2) imm2 = immed_sel;
      if (c == 3) begin z3 = alu_zero; ex3 = ctl; end
      if (rf_wr_en) wd_at = rf_wd_sel;
      nwr += 32'(rf_wr_en);
      nreq += 32'(mem_req);
      nwe += 32'(mem_we);
      if (pc_en) begin
        done = 1; ncyc = c; sel_at = pc_sel; exl = ctl;
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("done", 32'(done), 32'd1);
    chk("cycles", 32'(ncyc), 32'(ecyc));
    case (k)
      1: chk("pc_sel", 32'(sel_at), 32'd1);
      2: chk("pc_sel", 32'(sel_at), 32'(z3));
      3: chk("pc_sel", 32'(sel_at), 32'(!z3));
      default: chk("pc_sel", 32'(sel_at), 32'd0);
    endcase
    chk("dec_imm", 32'(imm2), (k == 1) ? 32'd3 : 32'd0);
    chk("rf_wr", 32'(nwr), 32'(ewr));
    if (ewr == 1) chk("wd_sel", 32'(wd_at), 32'(k == 4));
    chk("mem_req", 32'(nreq), 32'(ereq));
    chk("mem_we", 32'(nwe), (k == 5) ? 32'(ereq) : 32'd0);
    if (ecyc >= 3) chk("exec_ctl", 32'(ex3), 32'(exp_ctl(op, fn)));
    if (ecyc > 3) chk("held_ctl", 32'(exl), 32'(exp_ctl(op, fn)));
    if (k == 6 || eto) exp_err = 1'b1;
    chk("err", 32'(err), 32'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal [9];
    logic [5:0] op;
    int nwr;
    legal = '{6'b100000, 6'b110000, 6'b110010, 6'b110011, 6'b111111,
              6'b000000, 6'b000001, 6'b001111, 6'b011111};
    reset = 1'b1;
    instr = '0;
    alu_zero = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(6'b110000, 4'h5, 0, 2, 1'b0);
    run_instr(6'b000000, 4'h0, 0, 1, 1'b0);
    run_instr(6'b000001, 4'h0, 0, 1, 1'b0);
    run_instr(6'b001111, 4'h0, 3, 2, 1'b0);
    run_instr(6'b011111, 4'h0, 0, 2, 1'b0);
    run_instr(6'b100000, 4'hA, 0, 2, 1'b0);
    run_instr(6'b111111, 4'h0, 0, 2, 1'b0);
    run_instr(6'b101010, 4'h0, 0, 2, 1'b0);
    run_instr(6'b110010, 4'h0, 0, 2, 1'b0);

    do_reset();
    chk("err_cleared", 32'(err), 32'd0);
    instr = {6'b001111, 26'd0};
    nwr = 0;
    repeat (5) begin
      mem_ack = 1'b0;
      @(negedge clk);
      nwr += 32'(rf_wr_en);
      @(posedge clk); #1;
    end
    chk("mid_mem_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1 chk("async_reset_outs", 32'(outs), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("no_wr_after_abort", 32'(nwr), 32'd0);
    run_instr(6'b110000, 4'h0, 0, 2, 1'b0);

`ifdef MULTICYCLE_CTRL_MEM_TIMEOUT_EN
    run_instr(6'b011111, 4'h0, 20, 2, 1'b1);
    do_reset();
    run_instr(6'b011111, 4'h0, TMO - 1, 2, 1'b0);
    run_instr(6'b001111, 4'h0, 20, 2, 1'b1);
    do_reset();
`endif

    for (int i = 0; i < 60; i++) begin
      if (exp_err && $urandom_range(0, 3) == 0) do_reset();
      if ($urandom_range(0, 9) == 9) begin
        op = 6'($urandom);
        while (kind(op) != 6) op = 6'($urandom);
      end else begin
        op = legal[$urandom_range(0, 8)];
      end
      run_instr(op, 4'($urandom), $urandom_range(0, 4), 2, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM that sequences the instruction-fetch stage and the downstream datapath: register file, ALU and data memory.
- Drives the fetch stage's PC enable and branch-select inputs.
- Decodes the fetched 32-bit instruction and issues per-cycle datapath enables and selects.
- Handshakes with data memory through a req/ack pair.

Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles in MEM before abort. Used only when the optional feature is compiled in.
- TO_W, 4: width of the timeout counter. Must satisfy 2**TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr  in  32  fetched instruction; stable from the FETCH-cycle negedge until the next pc_en
- alu_zero  in  1  ALU zero flag, combinational from the current ALU result
- mem_ack  in  1  data memory completion, sampled only in MEM
- pc_en  out  1  PC load enable
- pc_sel  out  1  0 = PC+4, 1 = PC+4+immed
- rf_wr_en  out  1  register file write enable
- rf_wd_sel  out  1  write-data source: 0 = ALU, 1 = memory
- rf_b_sel  out  1  second read address: 0 = instr[15:11], 1 = instr[20:16]
- alu_bin_sel  out  1  ALU B operand: 0 = RF, 1 = immediate
- alu_func  out  4  ALU operation
- immed_sel  out  2  immediate extension: 00 sign-ext, 01 zero-ext, 11 sign-ext<<2
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (store)
- err  out  1  sticky error flag (illegal opcode, or timeout when enabled)

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB.
- Reset: asserting reset forces FETCH asynchronously from any state, including mid-MEM. The latched opcode/func clear to 0, err clears, and all outputs are 0.
- Opcode is instr[31:26]; func is instr[3:0]. Both are latched into internal registers at the end of DECODE and used in all later states.
- Supported opcodes: R=100000, ADDI=110000, ANDI=110010, ORI=110011, B=111111, BEQ=000000, BNE=000001, LW=001111, SW=011111. Any other opcode is illegal.
- FETCH: all outputs 0. Always -> DECODE.
- DECODE:
  - B: pc_en=1, pc_sel=1, immed_sel=11, then -> FETCH.
  - Illegal: pc_en=1, pc_sel=0, err set, then -> FETCH.
  - All others -> EXEC.
- EXEC:
  - alu_func: R uses func; ADDI/LW/SW = 0000 (add); ANDI = 0010; ORI = 0011; BEQ/BNE = 0001 (sub).
  - alu_bin_sel = 1 for ADDI/ANDI/ORI/LW/SW.
  - immed_sel: 01 for ANDI/ORI, 00 for ADDI/LW/SW, 11 for BEQ/BNE.
  - rf_b_sel = 1 for SW/BEQ/BNE.
  - BEQ/BNE: pc_en=1, pc_sel = alu_zero (BEQ) or ~alu_zero (BNE). This is a Mealy output in this cycle. Then -> FETCH.
  - LW/SW -> MEM. R/ADDI/ANDI/ORI -> WB.
  - EXEC control values for ALU/immediate/rf_b selects are held through MEM and WB so operands stay valid.
- MEM:
  - mem_req=1; mem_we=1 for SW.
  - Stay in MEM while mem_ack=0.
  - On mem_ack: SW -> pc_en=1, pc_sel=0, then FETCH. LW -> WB.
  - An ack in the first MEM cycle gives a single-cycle MEM state.
  - mem_ack asserted in any other state is ignored.
- WB: rf_wr_en=1, rf_wd_sel = 1 for LW, pc_en=1, pc_sel=0. Then -> FETCH.
- Cycle counts:
  - B and illegal: 2 cycles.
  - BEQ/BNE: 3 cycles.
  - ALU ops: 4 cycles.
  - SW: 4+w cycles; LW: 5+w cycles, where w = wait cycles in MEM.
- pc_en is asserted in exactly one cycle per instruction.
- err stays set until reset.

Optional Feature:
- Macro: MULTICYCLE_CTRL_MEM_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on entry to MEM and increments each MEM cycle without mem_ack.
  - When it reaches MEM_TIMEOUT with no ack: deassert mem_req, set err, pulse pc_en with pc_sel=0, and go to FETCH. No register write occurs for LW.
  - An ack in the same cycle as the timeout wins.
- Undefined: the counter is absent and MEM waits indefinitely.

Decomposition:
- Shared package multicycle_pkg holds:
  - state enum;
  - opcode constants;
  - ALU function codes;
  - immed_sel codes.
- Sub-module ctrl_decode: purely combinational, mapping the latched opcode/func to alu_func, alu_bin_sel, immed_sel, rf_b_sel and instruction class. The FSM instantiates it.

Test Plan:
- Reset mid-MEM of LW with mem_ack=0 -> next posedge in FETCH; all outputs 0; no rf_wr_en pulse.
- ADDI (110000) -> pc_en seen in the 4th cycle only; WB has rf_wr_en=1; EXEC has alu_func=0000, alu_bin_sel=1, immed_sel=00.
- BEQ with alu_zero=1 -> EXEC gives pc_en=1, pc_sel=1. BNE with alu_zero=1 -> pc_sel=0. Both last 3 cycles.
- LW with mem_ack delayed 3 cycles -> mem_req high for 4 cycles; WB has rf_wd_sel=1, rf_wr_en=1; 8 cycles total.
- Opcode 101010 -> err=1 after DECODE; pc_en=1, pc_sel=0; err persists until reset.
- With macro defined, MEM_TIMEOUT=4, SW with no ack -> 4 MEM cycles, then err=1, pc_en pulse, FETCH. Ack on the 4th cycle completes normally with err=0.
